temp_input_conditioner: RTL and testbench

- Upstream stage of the temperature display/RGB block. Turns 9 raw slide switches into a clean, range-checked sign-magnitude temperature with BCD digits.
- Processing chain: synchronise sw_raw, debounce it, clamp the magnitude to 0..99, then convert to BCD with an iterative double-dabble FSM.
- Outputs are registered and change only with a one-cycle update strobe. The downstream stage takes digits and magnitude directly and needs no decode table.

---
 rtl/temp_input_conditioner.sv | 228 ++++++++++++++++++++++
 tb/tb_temp_input_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : temp_input_conditioner
//  Description : Synchronises and debounces 9 slide switches, clamps the
//                magnitude to 0..MAX_MAG and converts it to two BCD digits
//                with an iterative double-dabble FSM. Registered outputs
//                change together, flagged by a one-cycle update strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module temp_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int MAX_MAG         = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] sw_raw,
    output logic       temp_sign,
    output logic [7:0] temp_mag,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       out_of_range,
    output logic       update,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       c_MAX_MAG = 8'(MAX_MAG);
    localparam logic [2:0]       c_LAST_IT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [8:0]       sync1_q, sync2_q;
    logic [8:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       stable_q, stable_d;

    state_t           state_q, state_d;
    logic [19:0]      shreg_q, shreg_d;
    logic [2:0]       iter_q, iter_d;
    logic [7:0]       mag_q, mag_d;
    logic             sgn_q, sgn_d;
    logic             oor_q, oor_d;

    logic             temp_sign_q, temp_sign_d;
    logic [7:0]       temp_mag_q, temp_mag_d;
    logic [3:0]       bcd_tens_q, bcd_tens_d;
    logic [3:0]       bcd_ones_q, bcd_ones_d;
    logic             out_of_range_q, out_of_range_d;
    logic             update_q, update_d;

    logic             w_accept;
    logic [7:0]       w_clamp_mag;
    logic             w_clamp_oor;
    logic             w_clamp_sgn;
    logic [19:0]      w_adj;

    // Accept a new setting only when settled, different from the current one
    // and the converter is free; otherwise it waits with the counter saturated.
    assign w_accept = (cnt_q == c_CNT_MAX) && (sync2_q == cand_q) &&
                      (cand_q != stable_q) && (state_q == S_IDLE);

    // Two-flop synchroniser on all switch bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: restart on any change, count up to saturation
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != c_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (w_accept) begin
            stable_d = cand_q;
        end
    end

    // Debounce registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Clamp the accepted magnitude; a zero magnitude is never negative
    always_comb begin
        w_clamp_mag = stable_q[7:0];
        w_clamp_oor = 1'b0;
        if (stable_q[7:0] > c_MAX_MAG) begin
            w_clamp_mag = c_MAX_MAG;
            w_clamp_oor = 1'b1;
        end
        w_clamp_sgn = stable_q[8] && (w_clamp_mag != 8'd0);
    end

    // Double-dabble add-3 correction on each BCD nibble before the shift
    always_comb begin
        w_adj = shreg_q;
        if (shreg_q[11:8]  >= 4'd5) w_adj[11:8]  = shreg_q[11:8]  + 4'd3;
        if (shreg_q[15:12] >= 4'd5) w_adj[15:12] = shreg_q[15:12] + 4'd3;
        if (shreg_q[19:16] >= 4'd5) w_adj[19:16] = shreg_q[19:16] + 4'd3;
    end

    // Conversion FSM next-state and datapath
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        iter_d         = iter_q;
        mag_d          = mag_q;
        sgn_d          = sgn_q;
        oor_d          = oor_q;
        temp_sign_d    = temp_sign_q;
        temp_mag_d     = temp_mag_q;
        bcd_tens_d     = bcd_tens_q;
        bcd_ones_d     = bcd_ones_q;
        out_of_range_d = out_of_range_q;
        update_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d = {12'b0, w_clamp_mag};
                iter_d  = '0;
                mag_d   = w_clamp_mag;
                sgn_d   = w_clamp_sgn;
                oor_d   = w_clamp_oor;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = {w_adj[18:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == c_LAST_IT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Hundreds nibble is always zero thanks to the clamp
                temp_sign_d    = sgn_q;
                temp_mag_d     = mag_q;
                bcd_tens_d     = shreg_q[15:12];
                bcd_ones_d     = shreg_q[11:8];
                out_of_range_d = oor_q;
                update_d       = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and conversion working registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            iter_q  <= '0;
            mag_q   <= '0;
            sgn_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            mag_q   <= mag_d;
            sgn_q   <= sgn_d;
            oor_q   <= oor_d;
        end
    end

    // Output registers, loaded together in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_sign_q    <= 1'b0;
            temp_mag_q     <= '0;
            bcd_tens_q     <= '0;
            bcd_ones_q     <= '0;
            out_of_range_q <= 1'b0;
            update_q       <= 1'b0;
        end else begin
            temp_sign_q    <= temp_sign_d;
            temp_mag_q     <= temp_mag_d;
            bcd_tens_q     <= bcd_tens_d;
            bcd_ones_q     <= bcd_ones_d;
            out_of_range_q <= out_of_range_d;
            update_q       <= update_d;
        end
    end

    assign temp_sign    = temp_sign_q;
    assign temp_mag     = temp_mag_q;
    assign bcd_tens     = bcd_tens_q;
    assign bcd_ones     = bcd_ones_q;
    assign out_of_range = out_of_range_q;
    assign update       = update_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_temp_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temp_input_conditioner
//  Description : Scoreboard bench for temp_input_conditioner (DEBOUNCE_CYCLES=4)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_input_conditioner;

    logic       clk;
    logic       reset;
    logic [8:0] sw_raw;
    logic       temp_sign;
    logic [7:0] temp_mag;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       out_of_range;
    logic       update;
    logic       busy;

    temp_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .MAX_MAG         (99)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .temp_sign    (temp_sign),
        .temp_mag     (temp_mag),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .out_of_range (out_of_range),
        .update       (update),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sgn;
        logic [7:0] mag;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       oor;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_upd = 0;
    int   cyc   = 0;
    int   busy_cnt = 0;
    int   prev_upd_cyc = 0;
    int   last_gap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: clamp by comparison, digits by division
    function automatic exp_t model(input logic [8:0] raw);
        exp_t e;
        int   m;
        m      = (int'(raw[7:0]) > 99) ? 99 : int'(raw[7:0]);
        e.mag  = 8'(m);
        e.oor  = (int'(raw[7:0]) > 99);
        e.sgn  = raw[8] && (m != 0);
        e.tens = 4'(m / 10);
        e.ones = 4'(m % 10);
        return e;
    endfunction

    // Monitor: every update pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (update) begin
            n_upd++;
            last_gap     = cyc - prev_upd_cyc;
            prev_upd_cyc = cyc;
            check("busy_len", busy_cnt, 10);
            check("sb_has_entry", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sign", temp_sign, e.sgn);
                check("mag",  temp_mag,  e.mag);
                check("tens", bcd_tens,  e.tens);
                check("ones", bcd_ones,  e.ones);
                check("oor",  out_of_range, e.oor);
            end
        end
        if (busy) busy_cnt++;
        else      busy_cnt = 0;
    end

    task automatic drive(input logic [8:0] v, input bit push, input int hold);
        @(posedge clk);
        #1;
        sw_raw = v;
        if (push) sb_q.push_back(model(v));
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic wait_upd(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (n_upd >= target) break;
            @(posedge clk);
        end
        #1;
        check("upd_reached", (n_upd >= target), 1);
    endtask

    task automatic wait_busy(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (busy) break;
            @(posedge clk);
            #1;
        end
        check("busy_seen", busy, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sign"}, temp_sign, 0);
        check({tag, "_mag"},  temp_mag, 0);
        check({tag, "_tens"}, bcd_tens, 0);
        check({tag, "_ones"}, bcd_ones, 0);
        check({tag, "_oor"},  out_of_range, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset  = 1'b0;
        sw_raw = 9'h1FF;
        repeat (5) @(posedge clk);
        #1;
        check_zero("rst");
        check("rst_update", update, 0);

        // Release with 0x1FF held: clamps to -99 once debounced
        sb_q.push_back(model(9'h1FF));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("post_rel");
        wait_upd(1, 60);

        drive(9'h04D, 1'b1, 1);   // +77
        wait_upd(2, 60);
        drive(9'h1C8, 1'b1, 1);   // -200 -> -99, out of range
        wait_upd(3, 60);
        drive(9'h100, 1'b1, 1);   // negative zero -> +0
        wait_upd(4, 60);

        // Bit 3 glitches of 3 cycles never settle long enough
        for (int k = 0; k < 5; k++) begin
            drive(9'h108, 1'b0, 3);
            drive(9'h100, 1'b0, 3);
        end
        repeat (20) @(posedge clk);
        #1;
        check("glitch_no_upd", n_upd, 4);
        check("glitch_mag", temp_mag, 0);
        check("glitch_sign", temp_sign, 0);
        drive(9'h108, 1'b1, 1);   // held stable -> -8
        wait_upd(5, 60);

        // Change arrives while busy: second conversion starts right after DONE
        drive(9'h05A, 1'b1, 1);   // +90
        wait_busy(40);
        repeat (2) @(posedge clk);
        #1;
        sw_raw = 9'h123;          // -35
        sb_q.push_back(model(9'h123));
        wait_upd(7, 80);
        check("busy_gap", last_gap, 11);

        // Reset mid-conversion aborts it; nothing follows release
        drive(9'h042, 1'b0, 1);
        wait_busy(40);
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        sw_raw = 9'h000;
        #1;
        check_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_upd", n_upd, 7);
        check("abort_mag", temp_mag, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
